// File: rtl/t02_mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access sharing one wishbone manager port.
// Define T02_ARB_RR_EN for round-robin arbitration; the default build uses fixed data-over-fetch priority.
module t02_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,

    output logic [ADDR_W-1:0]   m_adr,
    output logic [DATA_W-1:0]   m_wdat,
    output logic [DATA_W/8-1:0] m_sel,
    output logic                m_read,
    output logic                m_write,
    input  logic [DATA_W-1:0]   m_rdat,
    input  logic                m_busy,

    output logic                grant_d
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    logic   cur_we;
    logic   pick_d;
    logic   can_grant;

`ifdef T02_ARB_RR_EN
    logic   rr_ptr_d;

    always_comb pick_d = d_req && (!i_req || rr_ptr_d);
`else
    always_comb pick_d = d_req;
`endif

    // The ack cycle is excluded: the finished requester may still be holding its req.
    always_comb can_grant = (i_req || d_req) && !i_ack && !d_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_adr   <= '0;
            m_wdat  <= '0;
            m_sel   <= '0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            grant_d <= 1'b0;
            cur_we  <= 1'b0;
`ifdef T02_ARB_RR_EN
            rr_ptr_d <= 1'b1;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        grant_d <= pick_d;
                        state   <= ISSUE;
                        if (pick_d) begin
                            m_adr   <= d_addr;
                            m_wdat  <= d_wdata;
                            m_sel   <= d_sel;
                            cur_we  <= d_we;
                            m_read  <= !d_we;
                            m_write <= d_we;
                        end else begin
                            m_adr   <= i_addr;
                            m_wdat  <= '0;
                            m_sel   <= '1;
                            cur_we  <= 1'b0;
                            m_read  <= 1'b1;
                            m_write <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_busy) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!m_busy) begin
                        if (!cur_we) begin
                            if (grant_d) begin
                                d_rdata <= m_rdat;
                            end else begin
                                i_rdata <= m_rdat;
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    d_ack <= grant_d;
                    i_ack <= !grant_d;
`ifdef T02_ARB_RR_EN
                    rr_ptr_d <= !grant_d;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Randomized bench for t02_mem_arbiter: a scripted manager and requesters, checked against a
// transaction-level model of grant order, handshake timing and memory contents.
module tb_t02_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] m_adr;
    logic [31:0] m_wdat;
    logic [3:0]  m_sel;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdat;
    logic        m_busy;
    logic        grant_d;

    t02_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_adr(m_adr), .m_wdat(m_wdat), .m_sel(m_sel), .m_read(m_read), .m_write(m_write),
        .m_rdat(m_rdat), .m_busy(m_busy), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] bus_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    // Transaction model: one grant in flight, timed from the cycle the arbiter samples a request.
    bit          act = 1'b0;
    bit          win_d, t_we, dut_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_sel;
    int          t_issue, t_rise, t_fall;
    int          free_from = 0;
    bit          exp_grant;
    logic [31:0] exp_ird, exp_drd;
    bit          comp_i, comp_d;
    int          i_repeat = 0;
    int          d_repeat = 0;
    bit          rand_mode = 1'b0;
    int          rand_left = 0;
    int          force_k = -1;
    int          force_n = -1;
    bit          dut_grants[$];
`ifdef T02_ARB_RR_EN
    bit          rr_ptr;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_seed(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return mem_seed(a);
    endfunction

    function automatic logic [31:0] mod_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return mem_seed(a);
    endfunction

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] v;
        v = bus_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = wd[8*b +: 8];
        bus_mem[a] = v;
    endtask

    task automatic mod_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] v;
        v = mod_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = wd[8*b +: 8];
        model_mem[a] = v;
    endtask

    task automatic model_reset();
        act       = 1'b0;
        exp_grant = 1'b0;
        exp_ird   = '0;
        exp_drd   = '0;
        free_from = cyc + 1;
`ifdef T02_ARB_RR_EN
        rr_ptr    = 1'b1;
`endif
    endtask

    task automatic arbitrate();
        if (!act && rst == 1'b0 && cyc >= free_from && (i_req || d_req)) begin
`ifdef T02_ARB_RR_EN
            win_d = (i_req && d_req) ? rr_ptr : d_req;
`else
            win_d = d_req;
`endif
            t_we    = win_d && d_we;
            t_addr  = win_d ? d_addr : i_addr;
            t_sel   = win_d ? d_sel : 4'hF;
            t_wdata = d_wdata;
            t_issue = cyc + 1;
            t_rise  = t_issue + ((force_k >= 0) ? force_k : int'($urandom_range(0, 2)));
            t_fall  = t_rise + ((force_n >= 0) ? force_n : int'($urandom_range(1, 3)));
            act     = 1'b1;
        end
    endtask

    task automatic check_cycle();
        bit cmd;
        comp_i = 1'b0;
        comp_d = 1'b0;
        if (act && cyc == t_issue) begin
            exp_grant = win_d;
            dut_grants.push_back(grant_d);
        end
        cmd = act && cyc >= t_issue && cyc <= t_rise;
        check("m_read", 32'(m_read), 32'(cmd && !t_we));
        check("m_write", 32'(m_write), 32'(cmd && t_we));
        check("i_ack", 32'(i_ack), 32'(act && cyc == t_fall + 2 && !win_d));
        check("d_ack", 32'(d_ack), 32'(act && cyc == t_fall + 2 && win_d));
        check("grant_d", 32'(grant_d), 32'(exp_grant));
        if (act && cyc >= t_issue && cyc <= t_fall) begin
            check("m_adr", m_adr, t_addr);
            check("m_sel", 32'(m_sel), 32'(t_sel));
            if (t_we) check("m_wdat", m_wdat, t_wdata);
        end
        if (act && cyc == t_fall + 2) begin
            if (t_we) mod_wr(t_addr, t_wdata, t_sel);
            else if (win_d) exp_drd = mod_rd(t_addr);
            else exp_ird = mod_rd(t_addr);
            check("i_rdata_ack", i_rdata, exp_ird);
            check("d_rdata_ack", d_rdata, exp_drd);
`ifdef T02_ARB_RR_EN
            rr_ptr = !win_d;
`endif
            comp_i    = !win_d;
            comp_d    = win_d;
            act       = 1'b0;
            free_from = cyc + 1;
        end else if (!act) begin
            check("i_rdata_hold", i_rdata, exp_ird);
            check("d_rdata_hold", d_rdata, exp_drd);
        end
    endtask

    task automatic drive_manager();
        m_rdat = $urandom;
        m_busy = act && cyc >= t_rise && cyc < t_fall;
        if (act && cyc == t_issue) dut_we = m_write;
        if (act && cyc == t_fall) begin
            if (dut_we) bus_wr(m_adr, m_wdat, m_sel);
            else m_rdat = bus_rd(m_adr);
        end
    endtask

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = 32'($urandom_range(0, 15) * 4);
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 15) * 4);
        d_wdata = $urandom;
        d_sel   = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_requesters();
        if (comp_i) begin
            if (i_repeat > 0) begin
                i_repeat--;
                new_i();
            end else if (rand_mode && rand_left > 0 && $urandom_range(0, 2) == 0) begin
                rand_left--;
                new_i();
            end else begin
                i_req = 1'b0;
            end
        end
        if (comp_d) begin
            if (d_repeat > 0) begin
                d_repeat--;
                new_d();
            end else if (rand_mode && rand_left > 0 && $urandom_range(0, 2) == 0) begin
                rand_left--;
                new_d();
            end else begin
                d_req = 1'b0;
            end
        end
        if (rand_mode && rand_left > 0) begin
            if (!i_req && $urandom_range(0, 3) == 0) begin
                rand_left--;
                new_i();
            end
            if (!d_req && rand_left > 0 && $urandom_range(0, 3) == 0) begin
                rand_left--;
                new_d();
            end
        end
    endtask

    task automatic step();
        arbitrate();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive_manager();
        drive_requesters();
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((act || i_req || d_req || (rand_mode && rand_left > 0)) && n < maxc) begin
            step();
            n++;
        end
        check("run_bound", 32'(n < maxc), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_m_adr", m_adr, 32'd0);
        check("rst_m_wdat", m_wdat, 32'd0);
        check("rst_m_sel", 32'(m_sel), 32'd0);
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_grant_d", 32'(grant_d), 32'd0);
    endtask

    task automatic check_grants(input logic [7:0] exp, input int n);
        logic [7:0] e;
        e = exp;
        check("grant_count", 32'(dut_grants.size()), 32'(n));
        for (int i = 0; i < n && i < dut_grants.size(); i++)
            check($sformatf("grant_seq%0d", i), 32'(dut_grants[i]), 32'(e[i]));
    endtask

    initial begin
        int n;
        int c0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
        m_busy = 1'b0; m_rdat = '0;
        model_reset();
        repeat (3) step();
        check_reset_vals();
        rst = 1'b0;
        step();

        // Single fetch, busy high three cycles
        bus_mem[32'h3300_0000]   = 32'hDEAD_BEEF;
        model_mem[32'h3300_0000] = 32'hDEAD_BEEF;
        force_k = 1; force_n = 3;
        i_req = 1'b1; i_addr = 32'h3300_0000;
        run_until_idle(60);
        check("fetch_data", i_rdata, 32'hDEAD_BEEF);
        step();

        // Partial data write, then read back the merged word
        force_k = 2; force_n = 1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678; d_sel = 4'h3;
        run_until_idle(60);
        step();
        force_k = 0; force_n = 2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        run_until_idle(60);
        step();

        // Zero-wait manager: ack four cycles after the request is sampled
        force_k = 0; force_n = 1;
        step();
        c0 = cyc;
        i_req = 1'b1; i_addr = 32'h20;
        for (n = 0; n < 12 && i_ack !== 1'b1; n++) step();
        check("zero_wait_latency", 32'(cyc - c0), 32'd4);
        run_until_idle(20);
        step();

        // Contention: two requests on each port, both raised together
        force_k = -1; force_n = -1;
        dut_grants.delete();
        i_repeat = 1; d_repeat = 1;
        new_i(); new_d();
        run_until_idle(200);
`ifdef T02_ARB_RR_EN
        check_grants(8'h05, 4);
`else
        check_grants(8'h03, 4);
`endif
        step();

        // Contention: data keeps re-requesting while a fetch waits
        dut_grants.delete();
        i_repeat = 0; d_repeat = 3;
        new_i(); new_d();
        run_until_idle(200);
`ifdef T02_ARB_RR_EN
        check_grants(8'h1D, 5);
`else
        check_grants(8'h0F, 5);
`endif
        step();

        // Reset while waiting on a busy manager
        force_k = 0; force_n = 4;
        i_req = 1'b1; i_addr = 32'h24;
        for (n = 0; n < 10 && !(act && cyc == t_issue + 2); n++) step();
        check("reached_wait", 32'(m_busy), 32'd1);
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        model_reset();
        step();
        check_reset_vals();
        rst = 1'b0;
        repeat (6) step();
        force_k = -1; force_n = -1;
        i_req = 1'b1; i_addr = 32'h28;
        run_until_idle(60);
        step();

        // Randomized traffic on both ports
        rand_mode = 1'b1;
        rand_left = 300;
        run_until_idle(20000);
        rand_mode = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t02_mem_arbiter.md
# t02_mem_arbiter

Two-port memory arbiter between the CPU's instruction-fetch and data-access paths and the single shared `t02_wishbone_manager` port. Accepts one request at a time, sequences it into the manager's level-request/BUSY handshake, returns read data with a one-cycle acknowledge, and resolves contention by fixed data priority or, when configured, round-robin.

## Interface
Parameters:
- `ADDR_W`, 32: address width, both ports and manager side.
- `DATA_W`, 32: data width; `DATA_W/8` byte selects.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `i_req` in 1: instruction fetch request (read only); held until `i_ack`.
- `i_addr` in ADDR_W: fetch address; stable while `i_req`.
- `i_rdata` out DATA_W: fetched word; valid in the `i_ack` cycle and held until the next instruction grant completes.
- `i_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read; stable while `d_req`.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_sel` in DATA_W/8: byte selects.
- `d_rdata` out DATA_W: read word; valid in the `d_ack` cycle, held after.
- `d_ack` out 1: one-cycle completion pulse.
- `m_adr` out ADDR_W: to manager `ADR_I`.
- `m_wdat` out DATA_W: to manager `CPU_DAT_I`.
- `m_sel` out DATA_W/8: to manager `SEL_I`; all ones for fetches.
- `m_read` out 1: to manager `READ_I`.
- `m_write` out 1: to manager `WRITE_I`.
- `m_rdat` in DATA_W: from manager `CPU_DAT_O`.
- `m_busy` in 1: from manager `BUSY_O`.
- `grant_d` out 1: current or last grant went to the data port (debug/LA).

## Operation
- State machine, states IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- IDLE:
  - If any `*_req` is asserted, select a winner, register its address, wdata, sel and we into the manager-side registers, record the winner in `grant_d`, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - Drive `m_read`, or `m_write` for a data write, together with the registered fields.
  - When `m_busy` = 1, go to WAIT.
  - If `m_busy` = 0, keep issuing.
- WAIT:
  - `m_read` and `m_write` are 0; fields are held.
  - When `m_busy` = 0, capture `m_rdat` into the winner's rdata register and go to DONE. Writes leave the rdata registers unchanged.
- DONE: pulse the winner's ack for one cycle, then go to IDLE.
- Arbitration (default): data wins over instruction when both are requesting in IDLE.
- A loser's request is not dropped. It must remain asserted; it is considered again in the next IDLE.
- A request that deasserts before its ack produces undefined results. Requesters must not do this.
- Only one outstanding transaction exists at a time. Exactly one ack is produced per grant.

## Timing
- Reset values: `m_read`=0, `m_write`=0, `m_adr`=0, `m_wdat`=0, `m_sel`=0, `i_ack`=0, `d_ack`=0, `i_rdata`=0, `d_rdata`=0, `grant_d`=0, state IDLE. The round-robin pointer resets to favour data.
- Cycle at which `req` is sampled high in IDLE = T0. Then:
  - `m_read`/`m_write` high from T1.
  - If `m_busy` rises at T1+k, state is WAIT at T2+k.
  - If `m_busy` falls at T1+k+n, ack is high at T1+k+n+2.
- Minimum request-to-ack latency is 4 cycles, with zero-wait manager (busy high exactly one cycle).
- Back-to-back: after DONE, the arbiter returns to IDLE. The earliest next issue follows 2 cycles after the ack.
- `rst` mid-transaction: all outputs return to reset values the next cycle and no ack is produced. The in-flight bus cycle is the manager's responsibility, since it shares the same reset.
- Simultaneous `i_req` and `d_req` in IDLE are resolved per the arbitration policy. A request arriving during ISSUE/WAIT/DONE waits for IDLE.

## Configuration
- `T02_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer flips to the other port after every completed grant.
  - On contention the pointed-to port wins; a lone requester always wins.
  - Guarantees no port waits more than one foreign transaction.
- Not defined: fixed priority, data over instruction. The pointer logic is absent.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=0x3300_0000; manager busy high 3 cycles, `m_rdat`=0xDEADBEEF → `m_read`=1, `m_sel`=0xF, `i_ack` one pulse, `i_rdata`=0xDEADBEEF, `d_ack` never asserts.
- Data write: `d_req`=1, `d_we`=1, `d_addr`=0x10, `d_wdata`=0x1234_5678, `d_sel`=0x3 → `m_write`=1 with those fields until busy rises, `d_ack` pulse, `d_rdata` unchanged.
- Contention without macro: `i_req` and `d_req` both high continuously → data served first, then instruction. Repeated data requests starve instruction.
- Contention with `T02_ARB_RR_EN`: both requesting for 4 transactions → grants alternate D, I, D, I (`grant_d` 1, 0, 1, 0).
- Zero-wait manager: busy high for exactly one cycle → ack exactly 4 cycles after req sampled. No duplicate `m_read` after busy seen.
- Reset mid-WAIT: assert `rst` while busy=1 → next cycle `m_read`=`m_write`=0, no ack. A fresh `i_req` after reset completes normally.
